// File: rtl/data_maker_param.sv
// Parametrised stimulus sequencer: issues NSAMPLES words in one of four patterns,
// flags the final word and raises END_SIM once a drain period has elapsed.
module data_maker_param #(
    parameter int          WIDTH     = 32,
    parameter int          NSAMPLES  = 16,
    parameter int          DRAIN     = 8,
    parameter logic [31:0] START_VAL = 32'd0,
    parameter logic [31:0] LFSR_SEED = 32'd1,
    parameter logic [31:0] POLY      = 32'h80200003
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic                          EN,
    input  logic [1:0]                    MODE,
    output logic [WIDTH-1:0]              DATA,
    output logic                          VOUT,
    output logic                          LAST,
    output logic [$clog2(NSAMPLES+1)-1:0] SAMPLE_CNT,
    output logic                          END_SIM
);

    localparam int CW = $clog2(NSAMPLES + 1);
    localparam int DW = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] START_W   = WIDTH'(START_VAL);
    localparam logic [WIDTH-1:0] POLY_W    = WIDTH'(POLY);
    localparam logic [WIDTH-1:0] SEED_RAW  = WIDTH'(LFSR_SEED);
    // A zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [WIDTH-1:0] SEED_W    = (SEED_RAW == '0) ? ONE : SEED_RAW;
    localparam logic [CW-1:0]    LAST_IDX  = CW'(NSAMPLES - 1);
    localparam logic [DW-1:0]    DRAIN_INI = DW'(DRAIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg, mode_next;
    logic [WIDTH-1:0] pat_reg, pat_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             vout_reg, vout_next;
    logic             last_reg, last_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [DW-1:0]    drain_reg, drain_next;
    logic             end_reg, end_next;

    logic             issue;
    logic [WIDTH-1:0] word;
    logic [1:0]       issue_mode;

    function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
        case (m)
            2'd1:    seed_of = SEED_W;
            2'd3:    seed_of = ONE;
            default: seed_of = START_W;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic [1:0] m);
        case (m)
            2'd0:    step = x + ONE;
            2'd1:    step = (x >> 1) ^ (x[0] ? POLY_W : '0);
            2'd3:    step = {x[WIDTH-2:0], x[WIDTH-1]};
            default: step = x;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg <= S_IDLE;
            mode_reg  <= 2'd0;
            pat_reg   <= START_W;
            data_reg  <= '0;
            vout_reg  <= 1'b0;
            last_reg  <= 1'b0;
            cnt_reg   <= '0;
            drain_reg <= '0;
            end_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            pat_reg   <= pat_next;
            data_reg  <= data_next;
            vout_reg  <= vout_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            drain_reg <= drain_next;
            end_reg   <= end_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        pat_next   = pat_reg;
        data_next  = data_reg;
        vout_next  = 1'b0;
        last_next  = 1'b0;
        cnt_next   = cnt_reg;
        drain_next = drain_reg;
        end_next   = end_reg;
        issue      = 1'b0;
        word       = pat_reg;
        issue_mode = mode_reg;

        case (state_reg)
            S_IDLE: begin
                mode_next = MODE;
                pat_next  = seed_of(MODE);
                if (EN) begin
                    issue      = 1'b1;
                    word       = seed_of(MODE);
                    issue_mode = MODE;
                end
            end
            S_RUN: begin
                issue = EN;
            end
            // The LAST cycle itself is spent here, so END_SIM lands DRAIN+1 cycles after it
            S_DRAIN: begin
                if (drain_reg == '0) begin
                    state_next = S_DONE;
                    end_next   = 1'b1;
                end else begin
                    drain_next = drain_reg - 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (issue) begin
            data_next = word;
            pat_next  = step(word, issue_mode);
            vout_next = 1'b1;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == LAST_IDX) begin
                last_next  = 1'b1;
                state_next = S_DRAIN;
                drain_next = DRAIN_INI;
            end else begin
                state_next = S_RUN;
            end
        end
    end

    assign DATA       = data_reg;
    assign VOUT       = vout_reg;
    assign LAST       = last_reg;
    assign SAMPLE_CNT = cnt_reg;
    assign END_SIM    = end_reg;

endmodule

// File: tb/tb_data_maker_param.sv
// Directed bench for data_maker_param: three instances cover counter/LFSR/pause/reset,
// an 8-bit walking-one run, and the single-sample zero-drain corner.
module tb_data_maker_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: WIDTH=32, NSAMPLES=4, DRAIN=2, START_VAL=5
    logic        rst_a = 1'b0, en_a = 1'b0;
    logic [1:0]  mode_a = 2'd0;
    logic [31:0] data_a;
    logic        vout_a, last_a, end_a;
    logic [2:0]  cnt_a;

    // Instance B: WIDTH=8, NSAMPLES=10, DRAIN=1
    logic        rst_b = 1'b0, en_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic [7:0]  data_b;
    logic        vout_b, last_b, end_b;
    logic [3:0]  cnt_b;

    // Instance C: WIDTH=8, NSAMPLES=1, DRAIN=0, START_VAL=0x33
    logic        rst_c = 1'b0, en_c = 1'b0;
    logic [1:0]  mode_c = 2'd0;
    logic [7:0]  data_c;
    logic        vout_c, last_c, end_c;
    logic [0:0]  cnt_c;

    data_maker_param #(.WIDTH(32), .NSAMPLES(4), .DRAIN(2), .START_VAL(32'd5)) dut_a (
        .CLK(CLK), .RST_n(rst_a), .EN(en_a), .MODE(mode_a), .DATA(data_a),
        .VOUT(vout_a), .LAST(last_a), .SAMPLE_CNT(cnt_a), .END_SIM(end_a)
    );

    data_maker_param #(.WIDTH(8), .NSAMPLES(10), .DRAIN(1)) dut_b (
        .CLK(CLK), .RST_n(rst_b), .EN(en_b), .MODE(mode_b), .DATA(data_b),
        .VOUT(vout_b), .LAST(last_b), .SAMPLE_CNT(cnt_b), .END_SIM(end_b)
    );

    data_maker_param #(.WIDTH(8), .NSAMPLES(1), .DRAIN(0), .START_VAL(32'h33)) dut_c (
        .CLK(CLK), .RST_n(rst_c), .EN(en_c), .MODE(mode_c), .DATA(data_c),
        .VOUT(vout_c), .LAST(last_c), .SAMPLE_CNT(cnt_c), .END_SIM(end_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] lfsr_exp [4] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};
    logic [7:0]  walk_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    logic        en_seq   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] pz_data  [5] = '{32'd5, 32'd5, 32'd5, 32'd6, 32'd7};
    logic        pz_vout  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  pz_cnt   [5] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3};

    initial begin
        repeat (2) @(negedge CLK);

        // Reset state
        chk("rst_data", data_a, 32'd0);
        chk("rst_vout", {31'd0, vout_a}, 32'd0);
        chk("rst_last", {31'd0, last_a}, 32'd0);
        chk("rst_cnt", {29'd0, cnt_a}, 32'd0);
        chk("rst_end", {31'd0, end_a}, 32'd0);

        // Counter mode, EN held high from reset release
        mode_a = 2'd0; en_a = 1'b1; rst_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("cnt_data", data_a, 32'd5 + 32'(k));
            chk("cnt_vout", {31'd0, vout_a}, 32'd1);
            chk("cnt_last", {31'd0, last_a}, (k == 3) ? 32'd1 : 32'd0);
            chk("cnt_count", {29'd0, cnt_a}, 32'(k + 1));
        end
        for (int d = 1; d <= 3; d++) begin
            @(negedge CLK);
            chk("drain_vout", {31'd0, vout_a}, 32'd0);
            chk("drain_data", data_a, 32'd8);
            chk("drain_end", {31'd0, end_a}, (d == 3) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        chk("done_cnt", {29'd0, cnt_a}, 32'd4);
        chk("done_vout", {31'd0, vout_a}, 32'd0);
        chk("done_end", {31'd0, end_a}, 32'd1);

        // LFSR mode
        rst_a = 1'b0;
        @(negedge CLK);
        mode_a = 2'd1; rst_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("lfsr_data", data_a, lfsr_exp[k]);
            chk("lfsr_vout", {31'd0, vout_a}, 32'd1);
        end

        // Counter mode with EN pattern 1,0,0,1,1
        rst_a = 1'b0;
        @(negedge CLK);
        mode_a = 2'd0;
        for (int i = 0; i < 5; i++) begin
            en_a = en_seq[i];
            if (i == 0) rst_a = 1'b1;
            @(negedge CLK);
            chk("pause_data", data_a, pz_data[i]);
            chk("pause_vout", {31'd0, vout_a}, {31'd0, pz_vout[i]});
            chk("pause_cnt", {29'd0, cnt_a}, {29'd0, pz_cnt[i]});
        end

        // Asynchronous reset mid-run, then re-run
        rst_a = 1'b0;
        #1;
        chk("arst_data", data_a, 32'd0);
        chk("arst_vout", {31'd0, vout_a}, 32'd0);
        chk("arst_cnt", {29'd0, cnt_a}, 32'd0);
        @(negedge CLK);
        rst_a = 1'b1; en_a = 1'b1;
        @(negedge CLK);
        chk("rerun_data", data_a, 32'd5);
        chk("rerun_cnt", {29'd0, cnt_a}, 32'd1);

        // Walking one, 8 bits, 10 samples
        mode_b = 2'd3; en_b = 1'b1; rst_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("walk_data", {24'd0, data_b}, {24'd0, walk_exp[k]});
            chk("walk_last", {31'd0, last_b}, (k == 9) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        chk("walk_after_vout", {31'd0, vout_b}, 32'd0);
        chk("walk_after_cnt", {28'd0, cnt_b}, 32'd10);

        // Single sample, zero drain
        mode_c = 2'd0; en_c = 1'b1; rst_c = 1'b1;
        @(negedge CLK);
        chk("one_data", {24'd0, data_c}, 32'h33);
        chk("one_vout", {31'd0, vout_c}, 32'd1);
        chk("one_last", {31'd0, last_c}, 32'd1);
        chk("one_cnt", {31'd0, cnt_c}, 32'd1);
        chk("one_end_early", {31'd0, end_c}, 32'd0);
        @(negedge CLK);
        chk("one_end", {31'd0, end_c}, 32'd1);
        chk("one_vout_off", {31'd0, vout_c}, 32'd0);
        mode_c = 2'd2;
        repeat (3) @(negedge CLK);
        chk("done_mode_data", {24'd0, data_c}, 32'h33);
        chk("done_mode_vout", {31'd0, vout_c}, 32'd0);
        chk("done_mode_end", {31'd0, end_c}, 32'd1);
        chk("done_mode_cnt", {31'd0, cnt_c}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
